peak_framer: RTL and testbench



---
 rtl/peak_framer_if.sv | 29 ++
 rtl/peak_framer.sv | 219 +++++++++++++++++++++
 tb/tb_peak_framer.sv | 367 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/peak_framer_if.sv
// Stream bundle for peak_framer: the peak-entry sink (no backpressure) and the
// byte-serial packet source. A source byte transfers on a clock edge where
// source_valid && source_ready; while valid is high and ready low, the byte and
// its sop/eop flags stay unchanged until accepted.
interface peak_framer_if;
  logic        sink_valid;
  logic        sink_sop;
  logic        sink_eop;
  logic [23:0] sink_freq;
  logic [15:0] sink_phaseA;
  logic [15:0] sink_phaseB;
  logic        source_valid;
  logic        source_ready;
  logic [7:0]  source_data;
  logic        source_sop;
  logic        source_eop;

  modport master (
    output sink_valid, sink_sop, sink_eop, sink_freq, sink_phaseA, sink_phaseB,
    output source_ready,
    input  source_valid, source_data, source_sop, source_eop
  );

  modport slave (
    input  sink_valid, sink_sop, sink_eop, sink_freq, sink_phaseA, sink_phaseB,
    input  source_ready,
    output source_valid, source_data, source_sop, source_eop
  );
endinterface

// File: rtl/peak_framer.sv
// Captures one sop..eop run of peak entries into a single buffer and re-emits
// it as a byte packet: SYNC, seq, n, 7 bytes per entry, checksum.
module peak_framer #(
  parameter int         NPEAKS = 4,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  peak_framer_if.slave  bus,
  output logic [7:0]    drop_cnt,
  output logic [7:0]    err_cnt,
  output logic [1:0]    dbg_cap_state_o,
  output logic [2:0]    dbg_tx_state_o
);

  localparam int         IW    = (NPEAKS > 1) ? $clog2(NPEAKS) : 1;
  localparam int         DEPTH = 1 << IW;
  localparam logic [4:0] NMAX  = 5'(NPEAKS);

  typedef enum logic [1:0] {C_IDLE, C_RUN, C_DISCARD} cap_state_e;
  typedef enum logic [2:0] {T_IDLE, T_SYNC, T_SEQ, T_CNT, T_PAY, T_CHK} tx_state_e;

  cap_state_e  cap_state_q, cap_state_d;
  logic [4:0]  cap_n_q, cap_n_d;
  logic        cap_blk_q, cap_blk_d;
  tx_state_e   tx_state_q, tx_state_d;
  logic [4:0]  tx_n_q, tx_n_d;
  logic [4:0]  tx_e_q, tx_e_d;
  logic [2:0]  tx_b_q, tx_b_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  seq_q, seq_d;
  logic        pend_q, pend_d;
  logic [7:0]  drop_q, drop_d;
  logic [7:0]  err_q, err_d;

  logic [55:0] buf_q [DEPTH];
  logic [55:0] ent;
  logic [4:0]  wr_idx;
  logic        wr_en, complete, err_inc, launch, drop_inc;
  logic        hs, chk_hs, tx_reading;
  logic [7:0]  pay_byte;

  assign hs     = bus.source_valid && bus.source_ready;
  assign chk_hs = (tx_state_q == T_CHK) && hs;
  // Buffer is owned by TX from launch until the last payload byte is accepted.
  assign tx_reading = pend_q || (tx_state_q == T_SYNC) || (tx_state_q == T_SEQ) ||
                      (tx_state_q == T_CNT) || (tx_state_q == T_PAY);

  always_comb begin
    cap_state_d = cap_state_q;
    cap_n_d     = cap_n_q;
    cap_blk_d   = cap_blk_q;
    wr_en       = 1'b0;
    wr_idx      = cap_n_q;
    complete    = 1'b0;
    err_inc     = 1'b0;
    if (bus.sink_valid) begin
      if (bus.sink_sop) begin
        err_inc   = (cap_state_q == C_RUN);
        wr_idx    = '0;
        wr_en     = !tx_reading;
        cap_blk_d = tx_reading;
        cap_n_d   = 5'd1;
        if (bus.sink_eop) begin
          complete    = 1'b1;
          cap_state_d = C_IDLE;
        end else begin
          cap_state_d = C_RUN;
        end
      end else if (cap_state_q == C_RUN) begin
        if (cap_n_q == NMAX) begin
          err_inc     = 1'b1;
          cap_state_d = bus.sink_eop ? C_IDLE : C_DISCARD;
        end else begin
          wr_en   = !cap_blk_q;
          cap_n_d = cap_n_q + 5'd1;
          if (bus.sink_eop) begin
            complete    = 1'b1;
            cap_state_d = C_IDLE;
          end
        end
      end else if ((cap_state_q == C_DISCARD) && bus.sink_eop) begin
        cap_state_d = C_IDLE;
      end
    end
  end

  // A finishing checksum handshake frees TX in the same cycle, so a frame ending then still goes out.
  assign launch   = complete && !cap_blk_d &&
                    (((tx_state_q == T_IDLE) && !pend_q) || chk_hs);
  assign drop_inc = complete && !launch;

  always_comb begin
    drop_d = drop_q;
    err_d  = err_q;
    if (drop_inc && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    if (err_inc && (err_q != 8'hFF))   err_d  = err_q + 8'd1;
  end

  assign ent = buf_q[tx_e_q[IW-1:0]];

  always_comb begin
    case (tx_b_q)
      3'd0:    pay_byte = ent[55:48];
      3'd1:    pay_byte = ent[47:40];
      3'd2:    pay_byte = ent[39:32];
      3'd3:    pay_byte = ent[31:24];
      3'd4:    pay_byte = ent[23:16];
      3'd5:    pay_byte = ent[15:8];
      default: pay_byte = ent[7:0];
    endcase
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_n_d     = tx_n_q;
    tx_e_d     = tx_e_q;
    tx_b_d     = tx_b_q;
    sum_d      = sum_q;
    seq_d      = seq_q;
    pend_d     = pend_q;
    if (launch) tx_n_d = cap_n_d;
    case (tx_state_q)
      T_IDLE: begin
        if (pend_q) begin
          pend_d     = 1'b0;
          tx_state_d = T_SYNC;
        end else if (launch) begin
          tx_state_d = T_SYNC;
        end
      end
      T_SYNC: if (hs) begin
        sum_d      = 8'd0;
        tx_e_d     = '0;
        tx_b_d     = '0;
        tx_state_d = T_SEQ;
      end
      T_SEQ: if (hs) begin
        sum_d      = sum_q + seq_q;
        tx_state_d = T_CNT;
      end
      T_CNT: if (hs) begin
        sum_d      = sum_q + {3'b000, tx_n_q};
        tx_state_d = T_PAY;
      end
      T_PAY: if (hs) begin
        sum_d = sum_q + pay_byte;
        if (tx_b_q == 3'd6) begin
          tx_b_d = '0;
          if (tx_e_q == tx_n_q - 5'd1) tx_state_d = T_CHK;
          else                         tx_e_d     = tx_e_q + 5'd1;
        end else begin
          tx_b_d = tx_b_q + 3'd1;
        end
      end
      T_CHK: if (hs) begin
        seq_d      = seq_q + 8'd1;
        tx_state_d = T_IDLE;
        pend_d     = launch;
      end
      default: tx_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    bus.source_data = 8'h00;
    case (tx_state_q)
      T_SYNC:  bus.source_data = SYNC;
      T_SEQ:   bus.source_data = seq_q;
      T_CNT:   bus.source_data = {3'b000, tx_n_q};
      T_PAY:   bus.source_data = pay_byte;
      T_CHK:   bus.source_data = 8'h00 - sum_q;
      default: bus.source_data = 8'h00;
    endcase
  end

  assign bus.source_valid = (tx_state_q != T_IDLE);
  assign bus.source_sop   = (tx_state_q == T_SYNC);
  assign bus.source_eop   = (tx_state_q == T_CHK);
  assign drop_cnt         = drop_q;
  assign err_cnt          = err_q;
  assign dbg_cap_state_o  = cap_state_q;
  assign dbg_tx_state_o   = tx_state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_state_q <= C_IDLE;
      cap_n_q     <= '0;
      cap_blk_q   <= 1'b0;
      tx_state_q  <= T_IDLE;
      tx_n_q      <= '0;
      tx_e_q      <= '0;
      tx_b_q      <= '0;
      sum_q       <= '0;
      seq_q       <= '0;
      pend_q      <= 1'b0;
      drop_q      <= '0;
      err_q       <= '0;
    end else begin
      cap_state_q <= cap_state_d;
      cap_n_q     <= cap_n_d;
      cap_blk_q   <= cap_blk_d;
      tx_state_q  <= tx_state_d;
      tx_n_q      <= tx_n_d;
      tx_e_q      <= tx_e_d;
      tx_b_q      <= tx_b_d;
      sum_q       <= sum_d;
      seq_q       <= seq_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_q[wr_idx[IW-1:0]] <= {bus.sink_freq, bus.sink_phaseA, bus.sink_phaseB};
  end

endmodule

// File: tb/tb_peak_framer.sv
// Self-checking bench for peak_framer: packet bytes are predicted into a queue
// when frames are driven and checked on every cycle the DUT presents a byte.
module tb_peak_framer;

  logic       clk;
  logic       reset;
  logic [7:0] drop_cnt;
  logic [7:0] err_cnt;
  logic [1:0] dbg_cap_state;
  logic [2:0] dbg_tx_state;

  peak_framer_if bus ();

  peak_framer dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus),
    .drop_cnt        (drop_cnt),
    .err_cnt         (err_cnt),
    .dbg_cap_state_o (dbg_cap_state),
    .dbg_tx_state_o  (dbg_tx_state)
  );

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          rdy_mode = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  exp_seq  = 8'd0;
  logic [7:0]  exp_drop = 8'd0;
  logic [7:0]  exp_err  = 8'd0;
  logic [23:0] f_q [8];
  logic [15:0] a_q [8];
  logic [15:0] b_q [8];
  logic        in_pkt = 1'b0;
  logic        first_rdy = 1'b0;
  int          pkt_start = 0;
  int          last_span = -1;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bus.source_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.source_ready = 1'b1;
        1:       bus.source_ready = ~bus.source_ready;
        2:       bus.source_ready = 1'b0;
        default: bus.source_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Byte monitor: every presented byte must equal the queue head; pop on handshake.
  always @(negedge clk) begin
    if (reset && bus.source_valid) begin
      if (bus.source_sop && !in_pkt) begin
        in_pkt    = 1'b1;
        pkt_start = cyc;
        first_rdy = bus.source_ready;
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_byte got data=%h sop=%b eop=%b required none",
                 bus.source_data, bus.source_sop, bus.source_eop);
      end else if ({bus.source_sop, bus.source_eop, bus.source_data} !== exp_q[0]) begin
        bad++;
        $display("FAIL pkt_byte got sop/eop/data=%b/%b/%h required %b/%b/%h",
                 bus.source_sop, bus.source_eop, bus.source_data,
                 exp_q[0][9], exp_q[0][8], exp_q[0][7:0]);
      end
      if (bus.source_ready) begin
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        if (bus.source_eop) begin
          last_span = cyc - pkt_start;
          in_pkt    = 1'b0;
        end
      end
    end
  end

  function automatic void push_packet(input int n);
    logic [7:0] s;
    logic [7:0] bytes [7];
    s = exp_seq + 8'(n);
    exp_q.push_back({2'b10, 8'hA5});
    exp_q.push_back({2'b00, exp_seq});
    exp_q.push_back({2'b00, 8'(n)});
    for (int i = 0; i < n; i++) begin
      bytes[0] = f_q[i][23:16]; bytes[1] = f_q[i][15:8]; bytes[2] = f_q[i][7:0];
      bytes[3] = a_q[i][15:8];  bytes[4] = a_q[i][7:0];
      bytes[5] = b_q[i][15:8];  bytes[6] = b_q[i][7:0];
      for (int k = 0; k < 7; k++) begin
        exp_q.push_back({2'b00, bytes[k]});
        s = s + bytes[k];
      end
    end
    exp_q.push_back({2'b01, 8'h00 - s});
    exp_seq = exp_seq + 8'd1;
  endfunction

  task automatic send_raw(input logic sop, input logic eop, input int idx);
    @(posedge clk);
    #1;
    bus.sink_valid  = 1'b1;
    bus.sink_sop    = sop;
    bus.sink_eop    = eop;
    bus.sink_freq   = f_q[idx];
    bus.sink_phaseA = a_q[idx];
    bus.sink_phaseB = b_q[idx];
  endtask

  task automatic sink_idle();
    @(posedge clk);
    #1;
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
  endtask

  // Returns #1 after the edge that captured the eop entry.
  task automatic send_frame(input int n, input bit expect_tx);
    if (expect_tx) push_packet(n);
    for (int i = 0; i < n; i++) send_raw(i == 0, i == n - 1, i);
    sink_idle();
  endtask

  task automatic wait_drain(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !bus.source_valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain_timeout got remaining=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_counters(input string tag);
    total++;
    if (drop_cnt !== exp_drop) begin
      bad++;
      $display("FAIL %s_drop_cnt got=%0d required=%0d", tag, drop_cnt, exp_drop);
    end
    total++;
    if (err_cnt !== exp_err) begin
      bad++;
      $display("FAIL %s_err_cnt got=%0d required=%0d", tag, err_cnt, exp_err);
    end
  endtask

  task automatic set_frame2();
    f_q[0] = 24'h012345; a_q[0] = 16'h4000; b_q[0] = 16'hC000;
    f_q[1] = 24'h000064; a_q[1] = 16'h0001; b_q[1] = 16'hFFFF;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.sink_valid = 1'b0; bus.sink_sop = 1'b0; bus.sink_eop = 1'b0;
    bus.sink_freq = '0; bus.sink_phaseA = '0; bus.sink_phaseB = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({bus.source_valid, bus.source_sop, bus.source_eop, bus.source_data} !== 11'd0) begin
      bad++;
      $display("FAIL reset_source got v/s/e/d=%b/%b/%b/%h required 0",
               bus.source_valid, bus.source_sop, bus.source_eop, bus.source_data);
    end
    check_counters("reset");
    total++;
    if ({dbg_cap_state, dbg_tx_state} !== 5'd0) begin
      bad++;
      $display("FAIL reset_states got cap=%0d tx=%0d required 0", dbg_cap_state, dbg_tx_state);
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    rdy_mode = 0;
    set_frame2();
    send_frame(2, 1'b1);
    total++;
    if (bus.source_valid !== 1'b1 || bus.source_sop !== 1'b1) begin
      bad++;
      $display("FAIL basic_latency got valid=%b sop=%b required 1/1",
               bus.source_valid, bus.source_sop);
    end
    wait_drain(200);
    check_counters("basic");
  endtask

  task automatic test_stall();
    rdy_mode = 1;
    set_frame2();
    last_span = -1;
    send_frame(2, 1'b1);
    wait_drain(300);
    total++;
    if (last_span != (first_rdy ? 34 : 35)) begin
      bad++;
      $display("FAIL stall_span got=%0d required=%0d", last_span, first_rdy ? 34 : 35);
    end
    rdy_mode = 0;
  endtask

  task automatic test_single();
    rdy_mode = 0;
    for (int r = 0; r < 2; r++) begin
      f_q[0] = 24'($urandom_range(0, 24'hFFFFFF));
      a_q[0] = 16'($urandom_range(0, 16'hFFFF));
      b_q[0] = 16'($urandom_range(0, 16'hFFFF));
      send_frame(1, 1'b1);
      wait_drain(100);
    end
    check_counters("single");
  endtask

  task automatic test_overflow();
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) begin
      f_q[i] = 24'(i * 3 + 1); a_q[i] = 16'(i); b_q[i] = 16'hA000 + 16'(i);
    end
    send_frame(5, 1'b0);
    exp_err = exp_err + 8'd1;
    repeat (4) @(posedge clk);
    #1;
    check_counters("overflow");
    set_frame2();
    send_frame(2, 1'b1);
    wait_drain(200);
    // sop restart inside a running frame: counted as malformed, new frame is kept
    send_raw(1'b1, 1'b0, 0);
    send_raw(1'b0, 1'b0, 1);
    exp_err = exp_err + 8'd1;
    f_q[0] = 24'hABCDEF; a_q[0] = 16'h7FFF; b_q[0] = 16'h8000;
    f_q[1] = 24'h000001; a_q[1] = 16'h1234; b_q[1] = 16'h5678;
    send_frame(2, 1'b1);
    wait_drain(200);
    check_counters("restart");
  endtask

  task automatic test_drop();
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    set_frame2();
    send_frame(2, 1'b1);
    repeat (2) @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      f_q[i] = 24'h111111 * 24'(i + 1); a_q[i] = 16'h2222; b_q[i] = 16'h3333;
    end
    send_frame(3, 1'b0);
    send_frame(1, 1'b0);
    exp_drop = exp_drop + 8'd2;
    check_counters("drop");
    rdy_mode = 0;
    wait_drain(200);
    check_counters("drop_after");
  endtask

  task automatic test_back_to_back();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    f_q[0] = 24'h00BEEF; a_q[0] = 16'h0102; b_q[0] = 16'h0304;
    send_frame(1, 1'b1);
    repeat (9) @(posedge clk);
    f_q[0] = 24'hC0FFEE; a_q[0] = 16'hFEDC; b_q[0] = 16'h0BA9;
    push_packet(1);
    send_raw(1'b1, 1'b1, 0);
    sink_idle();
    total++;
    if (bus.source_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_gap got valid=%b required 0", bus.source_valid);
    end
    @(posedge clk);
    #1;
    total++;
    if (bus.source_valid !== 1'b1 || bus.source_sop !== 1'b1) begin
      bad++;
      $display("FAIL b2b_start got valid=%b sop=%b required 1/1",
               bus.source_valid, bus.source_sop);
    end
    wait_drain(100);
    check_counters("b2b");
  endtask

  task automatic test_random();
    rdy_mode = 3;
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        f_q[i] = 24'($urandom_range(0, 24'hFFFFFF));
        a_q[i] = 16'($urandom_range(0, 16'hFFFF));
        b_q[i] = 16'($urandom_range(0, 16'hFFFF));
      end
      send_frame(n, 1'b1);
      wait_drain(400);
    end
    rdy_mode = 0;
    check_counters("random");
  endtask

  task automatic test_reset_mid();
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    set_frame2();
    send_frame(2, 1'b1);
    repeat (6) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    total++;
    if ({bus.source_valid, bus.source_sop, bus.source_eop, bus.source_data,
         drop_cnt, err_cnt} !== 27'd0) begin
      bad++;
      $display("FAIL midreset_outputs got v=%b s=%b e=%b d=%h drop=%0d err=%0d required 0",
               bus.source_valid, bus.source_sop, bus.source_eop, bus.source_data,
               drop_cnt, err_cnt);
    end
    exp_q.delete();
    exp_seq = 8'd0; exp_drop = 8'd0; exp_err = 8'd0;
    in_pkt = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    f_q[0] = 24'h00FACE; a_q[0] = 16'h0F0F; b_q[0] = 16'hF0F0;
    send_frame(1, 1'b1);
    wait_drain(100);
    check_counters("midreset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_overflow();
    test_drop();
    test_back_to_back();
    test_random();
    test_reset_mid();
    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
